// File: rtl/kamikaze_muldiv_ctrl.sv
// kamikaze_muldiv_ctrl: iterative RV32M multiply/divide unit, one bit per cycle.
// The divider datapath is built only when KAMIKAZE_MULDIV_DIV_EN is defined.
module kamikaze_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic [4:0]       rd_i,
  input  logic             rf_rd_we_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       rf_rd_o,
  output logic             rf_rd_we_o
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [5:0] STEPS = 6'd32;

  logic [1:0]       state;
  logic [5:0]       count;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] opnd;
  logic             neg;
  logic             hi;
  logic [4:0]       rd_q;
  logic             we_q;

  logic             sgn1;
  logic             sgn2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] fix_res;

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    unique case (op_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sgn1 = op1_i[WIDTH-1];
        sgn2 = op2_i[WIDTH-1];
      end
      3'b010: sgn1 = op1_i[WIDTH-1];
      default: ;
    endcase
  end

  assign mag1 = sgn1 ? -op1_i : op1_i;
  assign mag2 = sgn2 ? -op2_i : op2_i;

  // Shift-add: high half accumulates, low half holds the shrinking multiplier.
  assign mul_sum  = {1'b0, acc[W2-1:WIDTH]}
                  + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign prod     = neg ? -acc : acc;

`ifdef KAMIKAZE_MULDIV_DIV_EN
  logic             is_div;
  logic             is_rem;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH:0]   div_diff;
  logic [W2-1:0]    div_next;
  logic [WIDTH-1:0] div_part;

  assign div_zero = (op2_i == '0);
  assign div_ovf  = !op_i[0] && &op2_i
                 && (op1_i == {1'b1, {(WIDTH-1){1'b0}}});
  // Restoring step: remainder in the high half, quotient bits shift in low.
  assign div_diff = acc[W2-1:WIDTH-1] - {1'b0, opnd};
  assign div_next = div_diff[WIDTH]
                  ? {acc[W2-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign div_part = is_rem ? acc[W2-1:WIDTH] : acc[WIDTH-1:0];
`endif

  always_comb begin
    fix_res = hi ? prod[W2-1:WIDTH] : prod[WIDTH-1:0];
`ifdef KAMIKAZE_MULDIV_DIV_EN
    if (is_div) fix_res = neg ? -div_part : div_part;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg      <= 1'b0;
      hi       <= 1'b0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      result_o <= '0;
      rf_rd_o  <= '0;
`ifdef KAMIKAZE_MULDIV_DIV_EN
      is_div   <= 1'b0;
      is_rem   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (start_i) begin
          state <= CALC;
          count <= STEPS;
          acc   <= {{WIDTH{1'b0}}, mag1};
          opnd  <= mag2;
          neg   <= sgn1 ^ sgn2;
          hi    <= (op_i[1:0] != 2'b00);
          rd_q  <= rd_i;
          we_q  <= rf_rd_we_i;
`ifdef KAMIKAZE_MULDIV_DIV_EN
          is_div <= op_i[2];
          is_rem <= op_i[1];
          if (op_i[2]) begin
            // Remainder takes the dividend's sign only.
            if (op_i[1]) neg <= sgn1;
            // Fixed-result cases park the answer in acc and bypass CALC.
            if (div_zero || div_ovf) begin
              state  <= FIX;
              count  <= '0;
              is_div <= 1'b0;
              neg    <= 1'b0;
              hi     <= 1'b0;
              if (div_zero)
                acc <= {{WIDTH{1'b0}},
                        op_i[1] ? op1_i : {WIDTH{1'b1}}};
              else
                acc <= {{WIDTH{1'b0}},
                        op_i[1] ? {WIDTH{1'b0}} : op1_i};
            end
          end
`else
          if (op_i[2]) begin
            state <= FIX;
            count <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            hi    <= 1'b0;
            we_q  <= 1'b0;
          end
`endif
        end
        CALC: begin
          count <= count - 6'd1;
`ifdef KAMIKAZE_MULDIV_DIV_EN
          acc <= is_div ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
          if (count == 6'd1) state <= FIX;
        end
        FIX: begin
          result_o <= fix_res;
          rf_rd_o  <= rd_q;
          state    <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);
  assign rf_rd_we_o = done_o & we_q;
  assign stall_o    = start_i & ~done_o;

endmodule

// File: tb/tb_kamikaze_muldiv_ctrl.sv
// tb_kamikaze_muldiv_ctrl: directed and random RV32M ops against a
// plain-arithmetic reference model; honours KAMIKAZE_MULDIV_DIV_EN.
module tb_kamikaze_muldiv_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        rf_rd_we_i = 1'b0;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rf_rd_o;
  logic        rf_rd_we_o;

  int vectors = 0;
  int miscompares = 0;

  kamikaze_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .op1_i(op1_i), .op2_i(op2_i), .rd_i(rd_i), .rf_rd_we_i(rf_rd_we_i),
    .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
    .result_o(result_o), .rf_rd_o(rf_rd_o), .rf_rd_we_o(rf_rd_we_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_ovf(input logic [31:0] a, input logic [31:0] b);
    return a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ss, su, uu;
    logic [31:0] r;
    ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    su = {{32{a[31]}}, a} * {32'b0, b};
    uu = {32'b0, a} * {32'b0, b};
    r = '0;
    case (op)
      3'd0: r = ss[31:0];
      3'd1: r = ss[63:32];
      3'd2: r = su[63:32];
      3'd3: r = uu[63:32];
`ifdef KAMIKAZE_MULDIV_DIV_EN
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : is_ovf(a, b) ? a
              : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : is_ovf(a, b) ? 32'h0
              : 32'($signed(a) % $signed(b));
      3'd7: r = (b == 0) ? a : a % b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!op[2]) return 34;
`ifdef KAMIKAZE_MULDIV_DIV_EN
    if (b == 0 || (!op[0] && is_ovf(a, b))) return 2;
    return 34;
`else
    return 2;
`endif
  endfunction

  function automatic logic ref_we(input logic [2:0] op, input logic we);
`ifdef KAMIKAZE_MULDIV_DIV_EN
    return we;
`else
    return op[2] ? 1'b0 : we;
`endif
  endfunction

  // One request held until done; inputs scrambled right after acceptance.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic we,
                        input logic [31:0] er, input int el,
                        input logic ewe);
    int k;
    bit seen;
    @(negedge clk_i);
    op_i = op; op1_i = a; op2_i = b; rd_i = rd; rf_rd_we_i = we;
    start_i = 1'b1;
    @(posedge clk_i);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 80) begin
      @(negedge clk_i);
      k++;
      if (k == 1) begin
        check({tag, "_busy"}, 64'(busy_o), 64'd1);
        check({tag, "_stall"}, 64'(stall_o), 64'd1);
        op_i = 3'($urandom); op1_i = $urandom; op2_i = $urandom;
        rd_i = 5'($urandom); rf_rd_we_i = 1'($urandom);
      end
      if (done_o) seen = 1'b1;
    end
    check({tag, "_lat"}, 64'(k), 64'(el));
    check({tag, "_res"}, 64'(result_o), 64'(er));
    check({tag, "_rd"}, 64'(rf_rd_o), 64'(rd));
    check({tag, "_we"}, 64'(rf_rd_we_o), 64'(ewe));
    check({tag, "_stall_done"}, 64'(stall_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_done_low"}, 64'({done_o, rf_rd_we_o}), 64'd0);
    check({tag, "_hold"}, 64'(result_o), 64'(er));
  endtask

  initial begin
    logic [2:0]  op, opb;
    logic [31:0] a, b, c, d;
    logic [4:0]  rd;
    logic        we;
    int          k, k1, ndone;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_out", 64'({busy_o, done_o, rf_rd_we_o, stall_o}), 64'd0);
    check("rst_res", 64'({result_o, 3'b0, rf_rd_o}), 64'd0);
    rst_i = 1'b0;

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1,
           32'hFFFF_FFEB, 34, 1'b1);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1,
           32'hFFFF_FFFE, 34, 1'b1);
    run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0,
           32'h0, 34, 1'b0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 1'b1,
           32'hFFFF_FFFF, 34, 1'b1);
`ifdef KAMIKAZE_MULDIV_DIV_EN
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1,
           32'hFFFF_FFFD, 34, 1'b1);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1,
           32'hFFFF_FFFF, 34, 1'b1);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd9, 1'b1, 32'd14, 34, 1'b1);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd10, 1'b1, 32'd2, 34, 1'b1);
    run_op("divu0", 3'd5, 32'd5, 32'd0, 5'd11, 1'b1,
           32'hFFFF_FFFF, 2, 1'b1);
    run_op("rem0", 3'd6, 32'd5, 32'd0, 5'd12, 1'b1, 32'd5, 2, 1'b1);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1,
           32'h8000_0000, 2, 1'b1);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1,
           32'h0, 2, 1'b1);
`else
    run_op("div_off", 3'd4, 32'd9, 32'd3, 5'd15, 1'b1, 32'h0, 2, 1'b0);
    run_op("remu_off", 3'd7, 32'd9, 32'd4, 5'd16, 1'b1, 32'h0, 2, 1'b0);
`endif

    // Reset in the middle of a multiply: nothing may complete.
    @(negedge clk_i);
    op_i = 3'd0; op1_i = 32'd12345; op2_i = 32'd678; rd_i = 5'd20;
    rf_rd_we_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i);
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("midrst_ctl", 64'({busy_o, done_o, rf_rd_we_o, stall_o}), 64'd0);
    check("midrst_res", 64'(result_o), 64'd0);
    check("midrst_rd", 64'(rf_rd_o), 64'd0);
    rst_i = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o || busy_o) ndone++;
    end
    check("midrst_quiet", 64'(ndone), 64'd0);

    // Request held through DONE, then retargeted to a second op.
    op = 3'd0; a = $urandom; b = $urandom;
    opb = 3'd3; c = $urandom; d = $urandom;
    @(negedge clk_i);
    op_i = op; op1_i = a; op2_i = b; rd_i = 5'd21; rf_rd_we_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i);
    k = 0; k1 = 0; ndone = 0;
    while (ndone < 2 && k < 120) begin
      @(negedge clk_i);
      k++;
      if (done_o) begin
        ndone++;
        if (ndone == 1) begin
          k1 = k;
          check("b2b_res1", 64'(result_o), 64'(ref_res(op, a, b)));
          op_i = opb; op1_i = c; op2_i = d; rd_i = 5'd22;
        end else begin
          check("b2b_res2", 64'(result_o), 64'(ref_res(opb, c, d)));
          check("b2b_rd2", 64'(rf_rd_o), 64'd22);
        end
      end
    end
    check("b2b_lat1", 64'(k1), 64'(ref_lat(op, a, b)));
    check("b2b_lat2", 64'(k), 64'(k1 + 1 + ref_lat(opb, c, d)));
    check("b2b_ndone", 64'(ndone), 64'd2);
    start_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a = $urandom; b = $urandom;
      case ($urandom_range(5, 0))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(300, 0)) - 32'd150;
                 b = 32'($urandom_range(20, 1)); end
        default: ;
      endcase
      rd = 5'($urandom);
      we = 1'($urandom);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, rd, we,
             ref_res(op, a, b), ref_lat(op, a, b), ref_we(op, we));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
